// File: rtl/seq_detect_moore.sv
// seq_detect_moore: serial pattern detector with runtime-loadable pattern,
// overlapping/non-overlapping mode and saturating match counter.
module seq_detect_moore #(
    parameter int unsigned           PAT_W   = 4,
    parameter int unsigned           CNT_W   = 8,
    parameter logic [PAT_W-1:0]      RST_PAT = 4'b1011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             inp,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);
    localparam int unsigned FW = $clog2(PAT_W + 1);

    typedef enum logic {FILL, ARMED} state_t;

    logic [PAT_W-1:0] pat_reg, hist, hist_nx;
    logic [FW-1:0]    fill, fill_nx;
    logic [CNT_W-1:0] cnt_inc;
    logic             hit;
    state_t           state;

    // Control state is implied by how many bits have been gathered.
    assign state   = (fill == FW'(PAT_W)) ? ARMED : FILL;
    assign hist_nx = {hist[PAT_W-2:0], inp};
    assign fill_nx = (state == ARMED) ? fill : fill + 1'b1;
    assign hit     = (fill_nx == FW'(PAT_W)) && (hist_nx == pat_reg);
    assign cnt_inc = match_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_reg   <= RST_PAT;
            hist      <= '0;
            fill      <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else if (load) begin
            pat_reg   <= pattern;
            hist      <= '0;
            fill      <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else if (en) begin
            match <= hit;
            hist  <= hist_nx;
            fill  <= (hit && !overlap) ? '0 : fill_nx;
            if (hit && !cnt_sat) begin
                match_cnt <= cnt_inc;
                cnt_sat   <= &cnt_inc;
            end
        end else begin
            match <= 1'b0;
        end
    end
endmodule

// File: tb/tb_seq_detect_moore.sv
// tb_seq_detect_moore: directed stimulus with a queued scoreboard; dut0 uses
// the default counter, dut1 a 2-bit counter for saturation.
module tb_seq_detect_moore;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en0 = 1'b0, inp0 = 1'b0, load0 = 1'b0, ov0 = 1'b0;
    logic       en1 = 1'b0, inp1 = 1'b0, load1 = 1'b0, ov1 = 1'b0;
    logic [3:0] pat0 = '0, pat1 = '0;
    logic       m0, s0, m1, s1;
    logic [7:0] c0;
    logic [1:0] c1;
    logic       ovl = 1'b1;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        bit   d;
        logic m;
        int   c;
        logic s;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    seq_detect_moore #(.PAT_W(4), .CNT_W(8), .RST_PAT(4'b1011)) dut0 (
        .clk(clk), .rst(rst), .en(en0), .inp(inp0), .load(load0), .pattern(pat0),
        .overlap(ov0), .match(m0), .match_cnt(c0), .cnt_sat(s0)
    );

    seq_detect_moore #(.PAT_W(4), .CNT_W(2), .RST_PAT(4'b1011)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .inp(inp1), .load(load1), .pattern(pat1),
        .overlap(ov1), .match(m1), .match_cnt(c1), .cnt_sat(s1)
    );

    // Monitor: outputs are settled by the falling edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic am, as;
            int   ac;
            e  = q.pop_front();
            am = e.d ? m1 : m0;
            ac = e.d ? int'(c1) : int'(c0);
            as = e.d ? s1 : s0;
            checks++;
            if (am !== e.m || ac != e.c || as !== e.s) begin
                errors++;
                $display("FAIL dut%0d step%0d: got match=%b cnt=%0d sat=%b, want match=%b cnt=%0d sat=%b",
                         e.d, checks, am, ac, as, e.m, e.c, e.s);
            end
        end
    end

    task automatic step(input bit d, input logic e, input logic i, input logic l,
                        input logic [3:0] p, input logic em, input int ec, input logic es);
        @(negedge clk);
        {en0, inp0, load0, en1, inp1, load1} = '0;
        if (d) begin
            en1 = e; inp1 = i; load1 = l; pat1 = p; ov1 = ovl;
        end else begin
            en0 = e; inp0 = i; load0 = l; pat0 = p; ov0 = ovl;
        end
        @(posedge clk);
        #1 q.push_back('{d, em, ec, es});
    endtask

    task automatic b(input bit d, input logic i, input logic em, input int ec, input logic es);
        step(d, 1'b1, i, 1'b0, 4'h0, em, ec, es);
    endtask

    task automatic ld(input bit d, input logic [3:0] p);
        step(d, 1'b0, 1'b0, 1'b1, p, 1'b0, 0, 1'b0);
    endtask

    task automatic idle(input int n, input int ec);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, ec, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // Bits offered under reset must leave everything at zero
        b(0, 1'b1, 0, 0, 0);
        b(0, 1'b1, 0, 0, 0);
        rst = 1'b1;

        // Reset pattern 1011, overlapping: 1,0,1,1,0,1,1
        ovl = 1'b1;
        b(0, 1, 0, 0, 0); b(0, 0, 0, 0, 0); b(0, 1, 0, 0, 0); b(0, 1, 1, 1, 0);
        b(0, 0, 0, 1, 0); b(0, 1, 0, 1, 0); b(0, 1, 1, 2, 0);

        // Same stream, non-overlapping
        ovl = 1'b0;
        ld(0, 4'b1011);
        b(0, 1, 0, 0, 0); b(0, 0, 0, 0, 0); b(0, 1, 0, 0, 0); b(0, 1, 1, 1, 0);
        b(0, 0, 0, 1, 0); b(0, 1, 0, 1, 0); b(0, 1, 0, 1, 0);

        // 1111 overlapping: pulses on bits 4,5,6
        ovl = 1'b1;
        ld(0, 4'b1111);
        b(0, 1, 0, 0, 0); b(0, 1, 0, 0, 0); b(0, 1, 0, 0, 0);
        b(0, 1, 1, 1, 0); b(0, 1, 1, 2, 0); b(0, 1, 1, 3, 0);

        // 1111 non-overlapping: pulse on bit 4 only
        ovl = 1'b0;
        ld(0, 4'b1111);
        b(0, 1, 0, 0, 0); b(0, 1, 0, 0, 0); b(0, 1, 0, 0, 0);
        b(0, 1, 1, 1, 0); b(0, 1, 0, 1, 0); b(0, 1, 0, 1, 0);

        // Gaps in en do not break the pattern
        ovl = 1'b1;
        ld(0, 4'b1011);
        b(0, 1, 0, 0, 0); idle(3, 0);
        b(0, 0, 0, 0, 0); idle(3, 0);
        b(0, 1, 0, 0, 0); idle(3, 0);
        b(0, 1, 1, 1, 0); idle(3, 1);

        // 2-bit counter saturates at 3 and holds; match keeps pulsing
        ld(1, 4'b1111);
        b(1, 1, 0, 0, 0); b(1, 1, 0, 0, 0); b(1, 1, 0, 0, 0);
        b(1, 1, 1, 1, 0); b(1, 1, 1, 2, 0); b(1, 1, 1, 3, 1);
        for (int k = 0; k < 4; k++) b(1, 1, 1, 3, 1);

        // Mid-pattern reset discards history and counter
        ld(0, 4'b1011);
        b(0, 1, 0, 0, 0); b(0, 0, 0, 0, 0); b(0, 1, 0, 0, 0); b(0, 1, 1, 1, 0);
        b(0, 1, 0, 1, 0); b(0, 0, 0, 1, 0); b(0, 1, 0, 1, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (m0 !== 1'b0 || c0 !== 8'd0 || s0 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got match=%b cnt=%0d sat=%b, want 0/0/0", m0, c0, s0);
        end
        @(negedge clk);
        rst = 1'b1;
        b(0, 1, 0, 0, 0);

        // load with en: the bit is dropped, so four more 1s are needed
        ovl = 1'b1;
        step(0, 1'b1, 1'b1, 1'b1, 4'b1111, 0, 0, 0);
        b(0, 1, 0, 0, 0); b(0, 1, 0, 0, 0); b(0, 1, 0, 0, 0); b(0, 1, 1, 1, 0);

        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_detect_moore.md
# seq_detect_moore

Parametrised Moore-style serial pattern detector: the next generation of the team's fixed two-bit sequence FSM. It shifts in one bit per enabled clock and compares the last PAT_W bits against a runtime-loadable pattern. It raises a registered one-cycle match pulse, supports overlapping and non-overlapping detection, and keeps a saturating match counter. It sits on serial control/data lines between the input synchroniser and the event/status logic.

## Interface
- PAT_W, 4: pattern length in bits (legal 2..16).
- CNT_W, 8: match counter width (legal 1..32).
- RST_PAT, 4'b1011: pattern value after reset (PAT_W bits).
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  one clock; reset is asynchronous and active-low.
- en  input  1  bit-valid strobe; inp is accepted only on edges where en=1.
- inp  input  1  serial data bit.
- load  input  1  load pattern and restart detection; has priority over en.
- pattern  input  PAT_W  new pattern, sampled when load=1; pattern[PAT_W-1] is the first bit received.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled each accepting edge.
- match  output  1  registered match pulse.
- match_cnt  output  CNT_W  number of matches since reset/load, saturating.
- cnt_sat  output  1  high when match_cnt is at all-ones.

## Operation
- Internal state: pat_reg (PAT_W), hist (PAT_W shift register, newest bit in LSB), fill (0..PAT_W).
- Two-state control derived from fill: FILL (fill<PAT_W) and ARMED (fill==PAT_W). In FILL, no match is possible.
- Reset (rst=0, asynchronous): pat_reg=RST_PAT, hist=0, fill=0, match=0, match_cnt=0, cnt_sat=0.
- load=1 edge: pat_reg<=pattern, hist<=0, fill<=0, match<=0, match_cnt<=0. inp is ignored on that edge even if en=1.
- Accepting edge (load=0, en=1):
  - hist_nx={hist[PAT_W-2:0],inp}.
  - fill_nx=min(fill+1,PAT_W).
  - hit=(fill_nx==PAT_W)&&(hist_nx==pat_reg).
  - match<=hit; hist<=hist_nx.
  - If hit and overlap=0, fill<=0 (next match needs PAT_W fresh bits). Otherwise fill<=fill_nx.
  - If hit and match_cnt is not all-ones, match_cnt increments by 1. At all-ones it holds; no wrap.
- Idle edge (load=0, en=0): hist, fill and match_cnt hold; match<=0.
- cnt_sat is registered and equals (match_cnt==all-ones) in the same cycle match_cnt takes that value.

## Timing
- Latency: match is high for the single clock period following the edge that accepted the completing bit, and low otherwise.
- Back-to-back matches in overlap mode produce consecutive-cycle pulses when en stays high (e.g. pattern 1111 with input 11111).
- The first possible match is on the PAT_W-th accepted bit after reset/load.
- rst is asserted asynchronously and takes effect immediately. Deassertion is synchronised externally. A reset mid-pattern discards partial history.
- Gaps in en do not break a pattern: matching is over accepted bits, not clock cycles.
- load and en in the same cycle: load wins, and the bit is dropped.

## Test plan
- Reset, PAT_W=4, RST_PAT=1011, overlap=1, stream 1,0,1,1,0,1,1 with en=1 → match pulses after the 4th and 7th bits; match_cnt=2; all outputs are 0 during reset.
- Same stream with overlap=0 → single match after the 4th bit (bits 5–7 give only 3 fresh bits); match_cnt=1.
- Load pattern 1111, overlap=1, feed six 1s → match after bits 4, 5 and 6 on consecutive cycles; match_cnt=3. Repeat with overlap=0 → match after bit 4 only.
- Stream 1,0,1,1 with en deasserted 3 cycles between each bit → one match pulse one cycle after the last accepting edge; match is 0 on all idle cycles.
- CNT_W=2, overlap=1, pattern 1111, feed ten 1s → match_cnt goes 1,2,3 and holds at 3; cnt_sat rises together with match_cnt=3.
- Assert rst=0 after 3 matching bits, release, then feed 1 bit → no match. Assert load together with en and inp=1 → the bit is dropped, fill=0 and match_cnt=0.
